ung_stream_scheduler: RTL

//  Shares one unary-stream datapath (value register + frame counter + comparator) among N_REQ requesters.

---
 rtl/ung_stream_scheduler_pkg.sv | 34 +++
 rtl/ung_stream_scheduler_rr_arbiter.sv | 51 +++++
 rtl/ung_stream_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ung_stream_scheduler_pkg.sv
// Shared types and the round-robin pick for the unary stream scheduler.
// Optional status counter is enabled with the UNG_SCHED_STATUS_EN macro.
package ung_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W     = 4;
  localparam int MAX_REQ   = 32;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  // One-hot pick of the first set bit of req after position ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] req,
                                                  input int ptr,
                                                  input int n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i <= n && !found && idx < MAX_REQ && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ung_stream_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational grant plus the last-winner pointer register.
// Used by ung_stream_scheduler (UNG_SCHED_STATUS_EN does not affect this file).
module ung_rr_arbiter
  import ung_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     en,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);

  localparam int OWNER_W = $clog2(N_REQ);

  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] grant_all;
  logic               unused_hi;

  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = req;
  end

  assign grant_all = rr_grant(req_ext, int'(ptr_q), N_REQ);
  assign unused_hi = ^grant_all[MAX_REQ-1:N_REQ];
  assign grant     = en ? grant_all[N_REQ-1:0] : '0;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = OWNER_W'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|grant) ptr_d = grant_idx;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= OWNER_W'(N_REQ - 1);
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ung_stream_scheduler.sv
// Shares one unary-stream datapath among N_REQ requesters, one 2^WIDTH-beat frame per grant.
// Define UNG_SCHED_STATUS_EN to add the frames_done status counter.
module ung_stream_scheduler
  import ung_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     abort,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic                     out_bit,
  output logic                     out_first,
  output logic                     out_last,
  output logic [$clog2(N_REQ)-1:0] out_owner,
  output logic                     busy
`ifdef UNG_SCHED_STATUS_EN
  ,
  output logic [15:0]              frames_done
`endif
);

  localparam int OWNER_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [OWNER_W-1:0] owner_q, owner_d;

  logic               streaming;
  logic               beat_acc;
  logic               last_acc;
  logic               grant_en;
  logic [N_REQ-1:0]   grant;
  logic [OWNER_W-1:0] grant_idx;
  logic [WIDTH-1:0]   grant_data;

  assign streaming = (state_q == STREAM);
  assign beat_acc  = streaming & out_ready;
  // An abort on the last beat ends the frame as aborted, not as completed.
  assign last_acc  = beat_acc & (&count_q) & ~abort;
  assign grant_en  = ~abort & ((state_q == IDLE) | last_acc);

  ung_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .en       (grant_en),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    value_d = value_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d = STREAM;
          count_d = '0;
          value_d = grant_data;
          owner_d = grant_idx;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (beat_acc) begin
          count_d = count_q + WIDTH'(1);
          if (&count_q) begin
            // Back-to-back frames: the next value loads on the wrapping beat.
            if (|grant) begin
              value_d = grant_data;
              owner_d = grant_idx;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      value_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      value_q <= value_d;
      owner_q <= owner_d;
    end
  end

  // The pointer update sees the ungated grant; reset gating applies only at the port.
  assign req_ready = rst ? grant : '0;
  assign out_valid = streaming;
  assign out_bit   = streaming & (count_q < value_q);
  assign out_first = streaming & (count_q == '0);
  assign out_last  = streaming & (&count_q) & ~abort;
  assign out_owner = owner_q;
  assign busy      = streaming;

`ifdef UNG_SCHED_STATUS_EN
  logic [15:0] frames_done_q, frames_done_d;

  always_comb begin
    frames_done_d = frames_done_q;
    if (last_acc) frames_done_d = frames_done_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frames_done_q <= '0;
    else      frames_done_q <= frames_done_d;
  end

  assign frames_done = frames_done_q;
`endif

endmodule
